// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through no-write-allocate data cache with one-word lines and hit/miss counters
module dcache_wt #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [1:0]  dsize,
    input  logic [31:0] daddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dready_n,
    output logic        dbusy,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int LINES = 1 << IDX_W;
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;
    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tags [LINES];
    logic [31:0]       r_lines [LINES];
    logic [31:0]       r_rdata, r_mem_addr, r_mem_wdata, r_hit_count, r_miss_count;
    logic [3:0]        r_mem_wstrb;
    logic              r_dready_n, r_mem_req, r_mem_we, r_flush_pend;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [1:0]        r_off, r_size;
    logic              w_word, w_half, w_inval, w_hit;
    logic [1:0]        w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [3:0]        w_strb;
    logic [31:0]       w_rep, w_mask, w_wdata, w_merged;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        return sz[1] ? s : sz[0] ? {16'b0, s[15:0]} : {24'b0, s[7:0]};
    endfunction

    // misaligned halves/words are silently aligned down
    assign w_word   = dsize[1];
    assign w_half   = dsize == 2'b01;
    assign w_off    = {daddr[1] & ~w_word, daddr[0] & ~w_word & ~w_half};
    assign w_idx    = daddr[2 +: IDX_W];
    assign w_tag    = daddr[31 -: TAG_W];
    assign w_inval  = flush | r_flush_pend;
    assign w_hit    = !w_inval && r_valid[w_idx] && r_tags[w_idx] == w_tag;
    assign w_strb   = w_word ? 4'hF : w_half ? 4'b0011 << {w_off[1], 1'b0} : 4'b0001 << w_off;
    assign w_rep    = w_word ? wdata : w_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign w_mask   = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign w_wdata  = w_rep & w_mask;
    assign w_merged = (r_lines[w_idx] & ~w_mask) | w_wdata;

    always_ff @(posedge clk) begin
        if (r_state == RD_MISS && mem_ack) begin
            r_lines[r_idx] <= mem_rdata;
            r_tags[r_idx]  <= r_tag;
        end else if (r_state == IDLE && dreq && dwrite && w_hit) begin
            r_lines[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_dready_n   <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_idx        <= '0;
            r_tag        <= '0;
            r_off        <= '0;
            r_size       <= '0;
        end else begin
            if (flush && r_state != IDLE)
                r_flush_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_inval) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end
                    if (dreq) begin
                        r_idx  <= w_idx;
                        r_tag  <= w_tag;
                        r_off  <= w_off;
                        r_size <= dsize;
                        if (dwrite) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {daddr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= w_strb;
                            r_state     <= WR_THRU;
                        end else if (w_hit) begin
                            r_rdata     <= extract(r_lines[w_idx], w_off, dsize);
                            r_hit_count <= r_hit_count + {31'b0, ~&r_hit_count};
                            r_dready_n  <= 1'b0;
                            r_state     <= RESP;
                        end else begin
                            r_miss_count <= r_miss_count + {31'b0, ~&r_miss_count};
                            r_mem_req    <= 1'b1;
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= {daddr[31:2], 2'b00};
                            r_mem_wstrb  <= 4'b0000;
                            r_state      <= RD_MISS;
                        end
                    end
                end
                RD_MISS: if (mem_ack) begin
                    r_valid[r_idx] <= 1'b1;
                    r_rdata        <= extract(mem_rdata, r_off, r_size);
                    r_mem_req      <= 1'b0;
                    r_dready_n     <= 1'b0;
                    r_state        <= RESP;
                end
                WR_THRU: if (mem_ack) begin
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_dready_n <= 1'b0;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_dready_n <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign dready_n   = r_dready_n;
    assign dbusy      = r_state == RD_MISS || r_state == WR_THRU;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed plus random accesses against a cache/memory reference model.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst, dreq, dwrite, flush, mem_ack;
    logic [1:0]  dsize;
    logic [31:0] daddr, wdata, mem_rdata;
    logic [31:0] rdata, mem_addr, mem_wdata, hit_count, miss_count;
    logic        dready_n, dbusy, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    dcache_wt dut (
        .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .dsize(dsize), .daddr(daddr),
        .wdata(wdata), .rdata(rdata), .dready_n(dready_n), .dbusy(dbusy), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] m_hit, m_miss;
    bit          m_pend;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    function automatic logic [1:0] offset(input logic [31:0] a, input logic [1:0] sz);
        return sz[1] ? 2'd0 : sz == 2'd1 ? {a[1], 1'b0} : a[1:0];
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic access(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input bit fl_same, input bit fl_mid);
        logic [31:0] wa, word, ew, v, exp_rd;
        logic [1:0]  off;
        logic [3:0]  strb;
        int          idx, cyc;
        bit          hit, done;
        @(negedge clk);
        chk("idle_dready_n", dready_n, 32'd1);
        dreq = 1'b1; dwrite = we; dsize = sz; daddr = a; wdata = wd; flush = fl_same;
        if (fl_same || m_pend) begin
            model_clear();
            m_pend = 1'b0;
        end
        off  = offset(a, sz);
        wa   = {a[31:2], 2'b00};
        idx  = int'(a[7:2]);
        hit  = !we && mv[idx] && mt[idx] == a[31:8];
        strb = sz[1] ? 4'hF : sz == 2'd1 ? 4'b0011 << off : 4'b0001 << off;
        ew   = '0;
        for (int i = 0; i < 4; i++)
            if (strb[i]) ew[8*i +: 8] = wd[8*(i-int'(off)) +: 8];
        if (!we) begin
            if (hit) m_hit = m_hit == 32'hFFFF_FFFF ? m_hit : m_hit + 1;
            else     m_miss = m_miss == 32'hFFFF_FFFF ? m_miss : m_miss + 1;
        end
        cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            flush   = fl_mid && !hit && cyc == 1;
            mem_ack = 1'b0;
            if (cyc == 1) begin
                chk("mem_req_issue", mem_req, {31'b0, !hit});
                chk("dbusy", dbusy, {31'b0, !hit});
                if (!hit) begin
                    chk("mem_addr", mem_addr, wa);
                    chk("mem_we", mem_we, {31'b0, we});
                    if (we) begin
                        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, strb});
                        chk("mem_wdata", mem_wdata & lanes(strb), ew);
                    end
                end
            end
            if (!dready_n) done = 1;
            else if (mem_req && cyc == lat) begin
                word = mem_word(wa);
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (strb[i]) word[8*i +: 8] = ew[8*i +: 8];
                    mem[wa] = word;
                end
                mem_rdata = word;
                mem_ack   = 1'b1;
            end
        end
        if (fl_mid && !hit) m_pend = 1'b1;
        chk("latency", cyc, hit ? 32'd1 : lat + 1);
        if (!we) begin
            v      = mem_word(wa) >> (8 * off);
            exp_rd = sz[1] ? v : sz == 2'd1 ? v & 32'hFFFF : v & 32'hFF;
            chk("rdata", rdata, exp_rd);
            if (!hit) begin
                mv[idx] = 1'b1;
                mt[idx] = a[31:8];
            end
        end
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
        dreq = 1'b0; mem_ack = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        m_pend = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dreq = 0; dwrite = 0; dsize = 2'd2; daddr = 0; wdata = 0; flush = 0;
        mem_ack = 0; mem_rdata = 0;
        m_hit = 0; m_miss = 0; m_pend = 0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_dready_n", dready_n, 32'd1);
        chk("rst_dbusy", dbusy, 32'd0);
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_hit", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        rst = 1'b0;

        mem[32'h100] = 32'hDEADBEEF;
        access(0, 2'd2, 32'h100, 0, 3, 0, 0);
        chk("cold_rdata", rdata, 32'hDEADBEEF);
        access(0, 2'd2, 32'h100, 0, 3, 0, 0);
        access(1, 2'd0, 32'h102, 32'h0000_00AA, 2, 0, 0);
        access(0, 2'd2, 32'h100, 0, 2, 0, 0);
        chk("merged_rdata", rdata, 32'hDEAABEEF);
        access(1, 2'd2, 32'h200, 32'hCAFE_F00D, 1, 0, 0);
        access(0, 2'd2, 32'h200, 0, 2, 0, 0);
        chk("no_alloc_rdata", rdata, 32'hCAFEF00D);
        mem[32'h300] = 32'h12345678;
        access(0, 2'd2, 32'h300, 0, 1, 0, 0);
        access(0, 2'd1, 32'h302, 0, 1, 0, 0);
        chk("half_rdata", rdata, 32'h00001234);
        access(0, 2'd0, 32'h303, 0, 1, 0, 0);
        chk("byte_rdata", rdata, 32'h00000012);
        access(0, 2'd2, 32'h400, 0, 3, 0, 1);
        access(0, 2'd2, 32'h400, 0, 2, 0, 0);
        access(0, 2'd2, 32'h400, 0, 2, 1, 0);

        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b0; dsize = 2'd2; daddr = 32'h500;
        @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", mem_req, 32'd0);
        chk("mid_rst_dbusy", dbusy, 32'd0);
        @(negedge clk);
        rst = 1'b0; dreq = 1'b0;
        model_clear(); m_pend = 0; m_hit = 0; m_miss = 0;
        access(0, 2'd2, 32'h500, 0, 2, 0, 0);

        @(negedge clk);
        force dut.r_miss_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_miss_count;
        m_miss = 32'hFFFF_FFFE;
        do_flush();
        access(0, 2'd2, 32'h600, 0, 1, 0, 0);
        do_flush();
        access(0, 2'd2, 32'h600, 0, 1, 0, 0);
        chk("miss_sat", miss_count, 32'hFFFF_FFFF);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) ? 32'h1000 : 32'h2000) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            access($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), a, $urandom,
                   $urandom_range(1, 4), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's MEM-stage data port and the backing data memory.
- Replaces the core's direct inout connection to memory, with split read and write data on the core side.
- Serves read hits in one cycle and reports its own wait states via dbusy/dready_n.
- Exports hit and miss counters for performance measurement.

Parameters:
- IDX_W, 6, index width; LINES = 2**IDX_W one-word lines.
- TAG_W, 24, tag width; must equal 30-IDX_W. Tag = daddr[31:2+IDX_W].

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- dreq  in  1  core data request; held with daddr/dwrite/dsize/wdata until dready_n is sampled low.
- dwrite  in  1  1=store, 0=load.
- dsize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- daddr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load data shifted right by 8*offset, upper bits zero per dsize. Sign extension is done by the core.
- dready_n  out  1  active-low completion; low for exactly one cycle per request.
- dbusy  out  1  high while a miss refill or write-through is outstanding.
- flush  in  1  one-cycle pulse; invalidate all lines.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing write.
- mem_addr  out  32  word-aligned address ([1:0]=00).
- mem_wdata  out  32  lane-placed store data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  32  refill word, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- hit_count  out  32  load hits; saturates at 32'hFFFFFFFF.
- miss_count  out  32  load misses; saturates.

Behaviour:
- Reset (async): state=IDLE; all valid bits cleared; dready_n=1; dbusy=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; rdata=0; both counters=0; pending flush cleared.
- Reset mid-refill or mid-write abandons the transaction; mem_req drops immediately.
- Alignment: half forces addr[0]=0; word forces addr[1:0]=00. No exception is raised.
- Strobes:
  - byte: 0001<<addr[1:0]
  - half: 0011<<(2*addr[1])
  - word: 1111
  - mem_wdata = wdata replicated into the selected lanes.
- States: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE, dreq=1, dwrite=0, tag match and valid: register rdata from the line; hit_count++; go to RESP.
- IDLE, dreq=1, dwrite=0, miss: miss_count++; drive mem_req=1, mem_we=0, mem_addr={daddr[31:2],2'b00}; go to RD_MISS.
- IDLE, dreq=1, dwrite=1: drive mem_req=1, mem_we=1, strobes and data; go to WR_THRU.
- RD_MISS: mem_* held stable until mem_ack. On mem_ack: line := mem_rdata, tag written, valid=1; rdata derived from mem_rdata; mem_req=0; go to RESP.
- WR_THRU: held until mem_ack. On a hit, the line is byte-merged in the IDLE->WR_THRU cycle; on a miss the line is untouched (no allocate). On mem_ack: mem_req=0; go to RESP.
- RESP: dready_n=0 for this one cycle; next state IDLE. A dreq still high in RESP is not re-sampled; a new request is accepted from the following cycle.
- dbusy = (state==RD_MISS || state==WR_THRU).
- Latency, dreq first sampled to dready_n low:
  - read hit: 1 cycle
  - read miss: mem_ack latency + 1
  - write: mem_ack latency + 1
- Flush:
  - In IDLE with no dreq: all valid bits clear at the next edge.
  - During RD_MISS, WR_THRU or RESP: a pending flag is set and applied on the first IDLE cycle. The refilled line is also invalidated.
  - flush and dreq in the same IDLE cycle (or pending flush plus dreq): invalidate first; the request is treated as a miss, or a non-hitting write.
- Counters saturate and do not wrap; writes are not counted.
- mem_ack outside RD_MISS/WR_THRU is ignored.

Test Plan:
- Cold load daddr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, dready_n low 4 cycles after dreq, rdata=0xDEADBEEF, miss_count=1. Repeat the load -> dready_n low after 1 cycle, mem_req stays 0, hit_count=1.
- After line 0x100 is cached, store byte 0xAA at 0x102 -> mem_wstrb=0100, mem_wdata lane2=0xAA. Then load word 0x100 hits with rdata=0xDEAABEEF.
- Store word to uncached 0x200, then load 0x200 -> the load misses (no allocate) and issues mem_req.
- Load half at 0x102 from line 0x12345678 -> rdata=0x00001234. Load byte at 0x103 -> rdata=0x00000012.
- flush pulsed during RD_MISS -> the refill completes with its response, then the next load to the same address misses. Also: flush and dreq in the same IDLE cycle -> that request misses.
- Assert rst while in RD_MISS -> mem_req=0 immediately; a subsequent load to the same address misses.
- Preload miss_count to 32'hFFFFFFFF via forced misses -> it stays 32'hFFFFFFFF.
